// File: rtl/emu_hash_seq.sv
// ---------------------------------------------------------------------------
// emu_hash_seq
//   On-board self-test sequencer for the hash emulator. A start pulse makes
//   it stream configuration and message bytes from a byte ROM into the hash
//   core. It then collects the hash bytes the core returns and compares them
//   against the expected bytes stored after the message in the same ROM.
//   The result is reported as sticky pass / fail / timeout flags, together
//   with the index of the first hash byte that did not match.
//
// Ports
//   clk          core clock
//   rst_async    asynchronous, active-high reset
//   start_i      start request (honoured only in IDLE and DONE)
//   rom_addr_o   ROM address (registered); ROM data returns one cycle later
//   rom_data_i   ROM read data
//   data_o       byte to the core (registered)
//   data_ctrl_o  [0] valid, [2:1] cmd: 01 cfg, 10 msg, 11 last msg, 00 idle
//   hash_i       hash byte from the core (already synchronised)
//   hash_ctrl_i  [0] hash byte strobe, [1] core ready for an input byte
//   busy_o       run in progress
//   done_o       run finished (sticky until next start)
//   pass_o       all hash bytes matched (sticky)
//   fail_o       mismatch or timeout (sticky)
//   timeout_o    stall counter expired (sticky)
//   err_idx_o    index of the first mismatching hash byte
// ---------------------------------------------------------------------------
module emu_hash_seq #(
  parameter  int CFG_BYTES  = 8,
  parameter  int MSG_BYTES  = 64,
  parameter  int HASH_BYTES = 32,
  parameter  int TIMEOUT_W  = 16,
  parameter  int ADDR_W     = $clog2(CFG_BYTES + MSG_BYTES + HASH_BYTES),
  localparam int IDX_W      = $clog2(HASH_BYTES)
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [7:0]        rom_data_i,
  output logic [7:0]        data_o,
  output logic [2:0]        data_ctrl_o,
  input  logic [7:0]        hash_i,
  input  logic [1:0]        hash_ctrl_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [IDX_W-1:0]  err_idx_o
);

  localparam int CNT_W = $clog2(HASH_BYTES + 1);

  localparam logic [ADDR_W-1:0] CFG_END  = ADDR_W'(CFG_BYTES);
  localparam logic [ADDR_W-1:0] LAST_MSG = ADDR_W'(CFG_BYTES + MSG_BYTES - 1);
  localparam logic [CNT_W-1:0]  K_LAST   = CNT_W'(HASH_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT_HASH,
    S_CHECK,
    S_DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     k_q;          // hash bytes received so far
  logic [7:0]           h_q;          // last received hash byte
  logic                 cmp_pending;  // h_q waits for its ROM byte
  logic [IDX_W-1:0]     cmp_idx;      // index of the byte held in h_q
  logic [TIMEOUT_W-1:0] stall_cnt;

  logic                 ready;
  logic                 hash_stb;
  logic                 mismatch;
  logic [TIMEOUT_W-1:0] stall_inc;
  logic                 stall_expire;
  logic [1:0]           cmd;

  assign ready    = hash_ctrl_i[1];
  assign hash_stb = hash_ctrl_i[0];

  // The ROM address advanced together with h_q, so rom_data_i now holds the
  // expected byte for the index captured in cmp_idx.
  assign mismatch = cmp_pending && (h_q != rom_data_i);

  // Expire on the cycle the counter would reach all-ones, so a 4-bit counter
  // allows 15 idle cycles before aborting.
  assign stall_inc    = stall_cnt + TIMEOUT_W'(1);
  assign stall_expire = (stall_inc == '1);

  always_comb begin
    if (rom_addr_o < CFG_END)        cmd = 2'b01;
    else if (rom_addr_o == LAST_MSG) cmd = 2'b11;
    else                             cmd = 2'b10;
  end

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // the async reset clears the control outputs immediately, without a clock.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state       <= S_IDLE;
      rom_addr_o  <= '0;
      data_o      <= '0;
      data_ctrl_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      timeout_o   <= 1'b0;
      err_idx_o   <= '0;
      k_q         <= '0;
      h_q         <= '0;
      cmp_pending <= 1'b0;
      cmp_idx     <= '0;
      stall_cnt   <= '0;
    end else begin
      // Single-cycle strobes fall back to idle unless re-asserted below.
      data_ctrl_o <= '0;
      cmp_pending <= 1'b0;

      // Only the first mismatch records its index; fail_o is still clear
      // at that point because timeout ends the run.
      if (mismatch && !fail_o) begin
        fail_o    <= 1'b1;
        err_idx_o <= cmp_idx;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            timeout_o  <= 1'b0;
            err_idx_o  <= '0;
            k_q        <= '0;
            stall_cnt  <= '0;
            rom_addr_o <= '0;
            busy_o     <= 1'b1;
            state      <= S_FETCH;
          end
        end

        S_FETCH: state <= S_SEND;

        S_SEND: begin
          if (ready) begin
            data_o      <= rom_data_i;
            data_ctrl_o <= {cmd, 1'b1};
            rom_addr_o  <= rom_addr_o + ADDR_W'(1);
            stall_cnt   <= '0;
            // After the last message byte the address lands on EXP_BASE.
            state       <= (rom_addr_o == LAST_MSG) ? S_WAIT_HASH : S_FETCH;
          end else if (stall_expire) begin
            timeout_o <= 1'b1;
            fail_o    <= 1'b1;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            state     <= S_DONE;
          end else begin
            stall_cnt <= stall_inc;
          end
        end

        S_WAIT_HASH: begin
          if (hash_stb) begin
            h_q         <= hash_i;
            cmp_pending <= 1'b1;
            cmp_idx     <= k_q[IDX_W-1:0];
            k_q         <= k_q + CNT_W'(1);
            rom_addr_o  <= rom_addr_o + ADDR_W'(1);
            stall_cnt   <= '0;
            if (k_q == K_LAST) state <= S_CHECK;
          end else if (stall_expire) begin
            timeout_o <= 1'b1;
            fail_o    <= 1'b1;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            state     <= S_DONE;
          end else begin
            stall_cnt <= stall_inc;
          end
        end

        // The final byte's compare is resolved this cycle; fold it into pass.
        S_CHECK: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          pass_o <= ~(fail_o | mismatch);
          state  <= S_DONE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emu_hash_seq.sv
// ---------------------------------------------------------------------------
// tb_emu_hash_seq
//   Directed bench for emu_hash_seq. A behavioural ROM and core model sit
//   around the sequencer; a negedge monitor records every valid byte pulse.
//   Cycle numbers are counted from the cycle in which start_i is high.
// ---------------------------------------------------------------------------
module tb_emu_hash_seq;

  localparam int CFG  = 8;
  localparam int MSG  = 64;
  localparam int HB   = 32;
  localparam int EXP  = CFG + MSG;
  localparam int NSTR = CFG + MSG;

  logic       clk = 1'b0;
  logic       rst_async = 1'b0;
  logic       start_i = 1'b0;
  logic [6:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] data_o;
  logic [2:0] data_ctrl;
  logic [7:0] hash_i = 8'h00;
  logic       ready = 1'b1;
  logic       hstb = 1'b0;
  logic       busy, done, pass, fail, tmo;
  logic [4:0] err_idx;

  logic [7:0] rom [0:127];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;

  logic mon_clr = 1'b0;
  int   mon_cnt, mon_err, n_cfg, n_msg, n_last, first_cyc, last_cyc, b8_cyc;

  emu_hash_seq #(
    .CFG_BYTES (CFG),
    .MSG_BYTES (MSG),
    .HASH_BYTES(HB),
    .TIMEOUT_W (4)
  ) dut (
    .clk        (clk),
    .rst_async  (rst_async),
    .start_i    (start_i),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .data_o     (data_o),
    .data_ctrl_o(data_ctrl),
    .hash_i     (hash_i),
    .hash_ctrl_i({ready, hstb}),
    .busy_o     (busy),
    .done_o     (done),
    .pass_o     (pass),
    .fail_o     (fail),
    .timeout_o  (tmo),
    .err_idx_o  (err_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_data <= rom[rom_addr];

  initial begin
    for (int i = 0; i < 128; i++) begin
      if (i < EXP) rom[i] = 8'(i * 7 + 3);
      else         rom[i] = 8'hA5 ^ 8'(i * 13);
    end
  end

  // Stream monitor: byte n must carry rom[n] with the right command.
  always @(negedge clk) begin
    if (mon_clr) begin
      mon_cnt <= 0; mon_err <= 0; n_cfg <= 0; n_msg <= 0; n_last <= 0;
      first_cyc <= -1; last_cyc <= -1; b8_cyc <= -1;
    end else if (data_ctrl[0]) begin
      logic [1:0] exp_cmd;
      if (mon_cnt < CFG)            exp_cmd = 2'b01;
      else if (mon_cnt == NSTR - 1) exp_cmd = 2'b11;
      else                          exp_cmd = 2'b10;
      if (mon_cnt >= NSTR || data_o !== rom[mon_cnt[6:0]] || data_ctrl[2:1] !== exp_cmd)
        mon_err <= mon_err + 1;
      case (data_ctrl[2:1])
        2'b01:   n_cfg  <= n_cfg + 1;
        2'b10:   n_msg  <= n_msg + 1;
        2'b11:   n_last <= n_last + 1;
        default: mon_err <= mon_err + 1;
      endcase
      if (mon_cnt == 0) first_cyc <= cyc - c0;
      if (mon_cnt == 8) b8_cyc <= cyc - c0;
      last_cyc <= cyc - c0;
      mon_cnt  <= mon_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, 32'(data_ctrl), 0);
    check({tag, "_data"}, 32'(data_o), 0);
    check({tag, "_addr"}, 32'(rom_addr), 0);
    check({tag, "_flags"}, {27'd0, busy, done, pass, fail, tmo}, 0);
    check({tag, "_erridx"}, 32'(err_idx), 0);
  endtask

  // Pulse start in cycle 0 and check the cycle-1 state.
  task automatic start_run(input string tag);
    @(posedge clk);
    #1 start_i = 1'b1; mon_clr = 1'b1; c0 = cyc;
    @(posedge clk);
    #1 start_i = 1'b0; mon_clr = 1'b0;
    @(negedge clk);
    check({tag, "_c1_addr"}, 32'(rom_addr), 0);
    check({tag, "_c1_busy"}, 32'(busy), 1);
    check({tag, "_c1_flags"}, {28'd0, done, pass, fail, tmo}, 0);
    check({tag, "_c1_erridx"}, 32'(err_idx), 0);
  endtask

  // Returns on a posedge once n pulses have been seen (bounded).
  task automatic wait_pulses(input string tag, input int n, input int budget);
    int i = 0;
    while (mon_cnt < n && i < budget) begin
      @(posedge clk);
      i++;
    end
    if (mon_cnt < n) check({tag, "_wait_pulses"}, mon_cnt, n);
  endtask

  task automatic check_stream(input string tag, input int exp_last);
    check({tag, "_pulses"}, mon_cnt, NSTR);
    check({tag, "_cfg"}, n_cfg, CFG);
    check({tag, "_msg"}, n_msg, MSG - 1);
    check({tag, "_last"}, n_last, 1);
    check({tag, "_bytes"}, mon_err, 0);
    check({tag, "_first_cyc"}, first_cyc, 3);
    check({tag, "_last_cyc"}, last_cyc, exp_last);
  endtask

  // Core model returns 32 back-to-back hash bytes, corrupting bad_a/bad_b.
  task automatic finish_run(input string tag, input int exp_last, input int bad_a,
                            input int bad_b, input bit exp_pass, input int exp_idx);
    wait_pulses(tag, NSTR, 600);
    check_stream(tag, exp_last);
    for (int i = 0; i < HB; i++) begin
      #1 hstb = 1'b1;
      hash_i = rom[EXP + i] ^ ((i == bad_a || i == bad_b) ? 8'hFF : 8'h00);
      @(posedge clk);
    end
    #1 hstb = 1'b0; hash_i = 8'h00;
    @(negedge clk);  // cycle t+1: final compare, not done yet
    check({tag, "_t1_done"}, 32'(done), 0);
    check({tag, "_t1_busy"}, 32'(busy), 1);
    @(negedge clk);  // cycle t+2: result visible
    check({tag, "_t2_done"}, 32'(done), 1);
    check({tag, "_t2_busy"}, 32'(busy), 0);
    check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    check({tag, "_fail"}, 32'(fail), 32'(!exp_pass));
    check({tag, "_erridx"}, 32'(err_idx), exp_idx);
    check({tag, "_tmo"}, 32'(tmo), 0);
    // Extra strobes after the run must be ignored.
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 hstb = 1'b1; hash_i = 8'h5A;
      @(posedge clk);
    end
    #1 hstb = 1'b0; hash_i = 8'h00;
    @(negedge clk);
    check({tag, "_extra_flags"}, {29'd0, done, pass, fail}, {29'd0, 1'b1, exp_pass, !exp_pass});
    check({tag, "_extra_erridx"}, 32'(err_idx), exp_idx);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1, "bench time limit");
  end

  initial begin
    int tcyc;

    // Reset state.
    rst_async = 1'b1;
    mon_clr   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_async = 1'b0;
    mon_clr   = 1'b0;

    // Matching hash.
    start_run("match");
    finish_run("match", 145, -1, -1, 1'b1, 0);

    // Mismatch on bytes 5 and 20; start from DONE clears the pass flag.
    start_run("mism");
    finish_run("mism", 145, 5, 20, 1'b0, 5);

    // Restart from DONE after a failure, with an ignored start while busy.
    start_run("restart");
    wait_pulses("restart", 30, 200);
    #1 start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    finish_run("restart", 145, -1, -1, 1'b1, 0);

    // Ready stall: 10 low cycles in front of byte 8.
    start_run("stall");
    wait_pulses("stall", 8, 100);
    #1 ready = 1'b0;
    repeat (10) @(posedge clk);
    #1 ready = 1'b1;
    finish_run("stall", 155, -1, -1, 1'b1, 0);
    check("stall_b8_cyc", b8_cyc, 29);

    // Timeout: core never answers; 4-bit counter expires 15 cycles in.
    start_run("tmo");
    wait_pulses("tmo", NSTR, 600);
    check_stream("tmo", 145);
    tcyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        tcyc = cyc - c0;
        break;
      end
    end
    check("tmo_done_cyc", tcyc, 160);
    check("tmo_flags", {27'd0, busy, done, pass, fail, tmo}, 5'b01011);
    check("tmo_ctrl", 32'(data_ctrl), 0);

    // Mid-run reset during the message bytes.
    start_run("rst");
    wait_pulses("rst", 20, 200);
    #1 rst_async = 1'b1;
    #1 check_idle_outputs("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_async = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_quiet_ctrl", 32'(data_ctrl), 0);
    check("midrst_quiet_pulses", mon_cnt, 20);
    start_run("rerun");
    finish_run("rerun", 145, -1, -1, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
